// File: rtl/button_conditioner.sv
// button_conditioner: N independent button channels, each with a synchroniser,
// a debounce FSM and a one-cycle action strobe (release, press or both edges),
// plus optional auto-repeat while a button is held.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-low reset
//   button[N]  raw asynchronous button levels, 1 = pressed
//   level[N]   debounced level, 1 = accepted as pressed
//   pulse[N]   one-cycle action strobe per channel
//   any_pulse  OR of pulse, same cycle

// ---------------------------------------------------------------------------
// bc_lane: one channel. Everything from the pin to the strobe lives here.
// ---------------------------------------------------------------------------
module bc_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic pulse
);
  localparam int  CW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int  RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int  RW     = $clog2(RMAX) + 1;
  localparam bit  REP_EN = (REPEAT_DELAY > 0) && (EDGE_MODE != 0);

  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [RW-1:0]          rc, rc_n;
  logic                   rep, rep_n;   // first repeat already fired; rc now counts periods
  logic                   press_ev, rel_ev, rep_ev;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rc_n     = rc;
    rep_n    = rep;
    press_ev = 1'b0;
    rel_ev   = 1'b0;
    rep_ev   = 1'b0;
    case (state)
      RELEASED:
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n  = PRESSED;
            press_ev = 1'b1;
          end else begin
            state_n = PRESS_PEND;
            cnt_n   = CW'(1);
          end
        end
      PRESS_PEND:
        if (!s) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n  = PRESSED;
          cnt_n    = '0;
          press_ev = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      PRESSED:
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = RELEASED;
            rel_ev  = 1'b1;
          end else begin
            state_n = RELEASE_PEND;
            cnt_n   = CW'(1);
          end
        end else if (REP_EN) begin
          // Repeat only counts while the button is still seen held, so a
          // repeat strobe can never land on the cycle that starts a release.
          rc_n = rc + RW'(1);
          if ((!rep && rc_n == RW'(REPEAT_DELAY)) || (rep && rc_n == RW'(REPEAT_PERIOD))) begin
            rep_ev = 1'b1;
            rc_n   = '0;
            rep_n  = 1'b1;
          end
        end
      RELEASE_PEND:
        // Bounce back to PRESSED keeps rc/rep so the repeat cadence continues.
        if (s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = RELEASED;
          cnt_n   = '0;
          rel_ev  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      default: state_n = RELEASED;
    endcase
    if (press_ev) begin
      rc_n  = '0;
      rep_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      state <= RELEASED;
      cnt   <= '0;
      rc    <= '0;
      rep   <= 1'b0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], button};
      state <= state_n;
      cnt   <= cnt_n;
      rc    <= rc_n;
      rep   <= rep_n;
      level <= (state_n == PRESSED) || (state_n == RELEASE_PEND);
      pulse <= (press_ev && EDGE_MODE != 0) || (rel_ev && EDGE_MODE != 1) || rep_ev;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// Top: array of lanes plus the shared any_pulse OR (built from registered
// pulses, so there is still no combinational path from button).
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] button,
  output logic [N-1:0] level,
  output logic [N-1:0] pulse,
  output logic         any_pulse
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    bc_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_MODE      (EDGE_MODE),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .button(button[i]),
      .level (level[i]),
      .pulse (pulse[i])
    );
  end

  assign any_pulse = |pulse;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner. Three instances share clk/reset:
//   u0 defaults (release pulse), u1 press + repeat (8/3), u2 both edges.
// Stimulus pushes expected pulses (instance, edge number, vector) into a
// queue; a monitor pops and compares whenever an instance strobes.
module tb_button_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] b0, b1, b2;
  logic [3:0] l0, l1, l2;
  logic [3:0] p0, p1, p2;
  logic       a0, a1, a2;
  logic [3:0] pv [3];
  logic       av [3];

  int edge_n = 0;
  int passes = 0;
  int total  = 0;

  typedef struct {
    int         dut;
    int         cyc;
    logic [3:0] p;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  button_conditioner u0 (.clk(clk), .reset(reset), .button(b0), .level(l0), .pulse(p0), .any_pulse(a0));
  button_conditioner #(.EDGE_MODE(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3))
    u1 (.clk(clk), .reset(reset), .button(b1), .level(l1), .pulse(p1), .any_pulse(a1));
  button_conditioner #(.EDGE_MODE(2))
    u2 (.clk(clk), .reset(reset), .button(b2), .level(l2), .pulse(p2), .any_pulse(a2));

  assign pv[0] = p0;
  assign pv[1] = p1;
  assign pv[2] = p2;
  assign av[0] = a0;
  assign av[1] = a1;
  assign av[2] = a2;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passes++;
    else $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, got, want);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int d, input int c, input logic [3:0] p);
    q.push_back('{dut: d, cyc: c, p: p});
  endtask

  // Monitor: every strobe must match the oldest expectation for its instance.
  always @(negedge clk) begin
    int idx;
    for (int d = 0; d < 3; d++) begin
      if (pv[d] != 4'b0 || av[d]) begin
        idx = -1;
        for (int k = 0; k < q.size(); k++)
          if (idx < 0 && q[k].dut == d) idx = k;
        if (idx < 0) begin
          chk($sformatf("unexpected_pulse_u%0d", d), 32'(pv[d]), 32'(0));
        end else begin
          chk($sformatf("pulse_edge_u%0d", d), 32'(edge_n), 32'(q[idx].cyc));
          chk($sformatf("pulse_vec_u%0d", d), 32'(pv[d]), 32'(q[idx].p));
          chk($sformatf("any_pulse_u%0d", d), 32'(av[d]), 32'(1));
          q.delete(idx);
        end
      end
    end
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].cyc < edge_n) begin
        total++;
        $display("FAIL missed_pulse u%0d want vec=%b at edge %0d got none", q[k].dut, q[k].p, q[k].cyc);
        q.delete(k);
      end
    end
  end

  initial begin
    int e0, e1;
    reset = 1'b0;
    b0 = '0; b1 = '0; b2 = '0;

    // Reset held two cycles, then idle: everything stays low.
    step(1);
    chk("rst_level", 32'({l0, l1, l2}), 32'(0));
    chk("rst_pulse", 32'({p0, p1, p2, a0, a1, a2}), 32'(0));
    step(1);
    reset = 1'b1;
    step(4);
    chk("idle_level", 32'({l0, l1, l2}), 32'(0));

    // u0 ch0: clean press, 10-cycle hold, release -> one release pulse.
    e0 = edge_n;
    b0[0] = 1'b1;
    step(5);
    chk("press_lat_lo", 32'(l0[0]), 32'(0));
    step(1);
    chk("press_lat_hi", 32'(l0[0]), 32'(1));
    step(4);
    e1 = edge_n;
    expect_pulse(0, e1 + 6, 4'b0001);
    b0[0] = 1'b0;
    step(5);
    chk("rel_lat_hi", 32'(l0[0]), 32'(1));
    step(1);
    chk("rel_lat_lo", 32'(l0[0]), 32'(0));
    step(4);

    // u0 ch1: 3-cycle press glitch is rejected.
    b0[1] = 1'b1;
    step(3);
    b0[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_press_level", 32'(l0[1]), 32'(0));
    end
    // Held with a 1-cycle low glitch: level stays up, no pulse.
    b0[1] = 1'b1;
    step(8);
    chk("held_level", 32'(l0[1]), 32'(1));
    b0[1] = 1'b0;
    step(1);
    b0[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_release_level", 32'(l0[1]), 32'(1));
    end
    e1 = edge_n;
    expect_pulse(0, e1 + 6, 4'b0010);
    b0[1] = 1'b0;
    step(8);

    // u2 both edges: ch2+ch3 together -> paired pulse on press and release.
    e0 = edge_n;
    expect_pulse(2, e0 + 6, 4'b1100);
    b2[3:2] = 2'b11;
    step(10);
    chk("both_level", 32'(l2), 32'(4'b1100));
    e1 = edge_n;
    expect_pulse(2, e1 + 6, 4'b1100);
    b2 = '0;
    step(10);

    // u1 press + repeat: acceptance at A, repeats at A+8, +11, +14, +17.
    // Button drops so the FSM first sees it low at A+20: no further repeat.
    e0 = edge_n;
    expect_pulse(1, e0 + 6, 4'b0001);
    expect_pulse(1, e0 + 14, 4'b0001);
    expect_pulse(1, e0 + 17, 4'b0001);
    expect_pulse(1, e0 + 20, 4'b0001);
    expect_pulse(1, e0 + 23, 4'b0001);
    b1[0] = 1'b1;
    step(23);
    b1[0] = 1'b0;
    step(5);
    chk("rep_rel_hi", 32'(l1[0]), 32'(1));
    step(1);
    chk("rep_rel_lo", 32'(l1[0]), 32'(0));
    step(6);

    // u0: reset while held -> immediate clear; re-debounced as a new press.
    b0[0] = 1'b1;
    step(7);
    chk("pre_rst_level", 32'(l0[0]), 32'(1));
    reset = 1'b0;
    #1;
    chk("async_rst_level", 32'(l0), 32'(0));
    chk("async_rst_pulse", 32'({p0, a0}), 32'(0));
    step(2);
    reset = 1'b1;
    e0 = edge_n;
    step(5);
    chk("post_rst_lo", 32'(l0[0]), 32'(0));
    step(1);
    chk("post_rst_hi", 32'(l0[0]), 32'(1));
    step(4);
    e1 = edge_n;
    expect_pulse(0, e1 + 6, 4'b0001);
    b0[0] = 1'b0;
    step(10);

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
